// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 pipelined bus between the wbdbgbus master and wb_ram_slave,
// including the stall/error injection hooks used by bench harnesses.
interface wb_ram_slave_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        i_force_stall;
    logic        i_force_error;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output i_force_stall, i_force_error,
        input  o_wb_ack, o_wb_err, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  i_force_stall, i_force_error,
        output o_wb_ack, o_wb_err, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Pipelined Wishbone B4 RAM slave with programmable response latency and stall/error hooks.
// Define WB_RAM_OOR_ERR_EN to answer out-of-range accesses with err instead of ack.
module wb_ram_slave #(
    parameter int MEMORY_DEPTH = 128,
    parameter int LATENCY      = 1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    wb_ram_slave_if.slave wb
);
    localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    logic [31:0]        mem [MEMORY_DEPTH];
    logic               accept;
    logic               in_range;
    logic               req_err;
    logic               mem_we;
    logic [AW-1:0]      mem_idx;
    logic [31:0]        req_data;
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic [LATENCY-1:0] err_q;
    logic [LATENCY-1:0] err_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];

    // Classification happens once, at acceptance; later stages only carry the result.
    always_comb begin
        accept   = wb.i_wb_cyc && wb.i_wb_stb && !wb.i_force_stall;
        in_range = wb.i_wb_addr < 32'(MEMORY_DEPTH);
        mem_idx  = wb.i_wb_addr[AW-1:0];
`ifdef WB_RAM_OOR_ERR_EN
        req_err  = wb.i_force_error || !in_range;
`else
        req_err  = wb.i_force_error;
`endif
        mem_we   = accept && wb.i_wb_we && in_range && !wb.i_force_error;
        req_data = 32'd0;
        if (in_range && !wb.i_force_error && !wb.i_wb_we) begin
            req_data = mem[mem_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wb.i_wb_data;
        end
    end

    // Dropping cyc aborts every in-flight response, not just new requests.
    always_comb begin
        valid_d[0] = accept;
        err_d[0]   = req_err;
        data_d[0]  = req_data;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = wb.i_wb_cyc && valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= 32'd0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign wb.o_wb_stall = wb.i_force_stall;
    assign wb.o_wb_ack   = valid_q[LATENCY-1] && !err_q[LATENCY-1];
    assign wb.o_wb_err   = valid_q[LATENCY-1] && err_q[LATENCY-1];
    assign wb.o_wb_data  = (valid_q[LATENCY-1] && !err_q[LATENCY-1]) ? data_q[LATENCY-1] : 32'd0;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: two instances (LATENCY 1 and 4) share one randomized
// request stream; a word-array reference model predicts every response slot.
`timescale 1ns/1ps
module tb_wb_ram_slave;
    localparam int DEPTH = 128;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;
`ifdef WB_RAM_OOR_ERR_EN
    localparam bit OOR_ERR = 1'b1;
`else
    localparam bit OOR_ERR = 1'b0;
`endif

    typedef struct {
        longint      due;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        cyc     = 1'b0;
    logic        stb     = 1'b0;
    logic        we      = 1'b0;
    logic        fstall  = 1'b0;
    logic        ferr    = 1'b0;
    logic [31:0] addr    = 32'd0;
    logic [31:0] wdata   = 32'd0;

    logic [31:0] mdl_mem [DEPTH];
    exp_t        q_a[$];
    exp_t        q_b[$];
    longint      edge_cnt = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;

    wb_ram_slave_if wb_a ();
    wb_ram_slave_if wb_b ();

    assign wb_a.i_wb_cyc      = cyc;
    assign wb_a.i_wb_stb      = stb;
    assign wb_a.i_wb_we       = we;
    assign wb_a.i_wb_addr     = addr;
    assign wb_a.i_wb_data     = wdata;
    assign wb_a.i_force_stall = fstall;
    assign wb_a.i_force_error = ferr;
    assign wb_b.i_wb_cyc      = cyc;
    assign wb_b.i_wb_stb      = stb;
    assign wb_b.i_wb_we       = we;
    assign wb_b.i_wb_addr     = addr;
    assign wb_b.i_wb_data     = wdata;
    assign wb_b.i_force_stall = fstall;
    assign wb_b.i_force_error = ferr;

    wb_ram_slave #(.MEMORY_DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wb      (wb_a)
    );

    wb_ram_slave #(.MEMORY_DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wb      (wb_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic apply_stimulus(input logic c, input logic s, input logic w,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic fs, input logic fe);
        @(negedge i_clk);
        cyc = c; stb = s; we = w; addr = a; wdata = d; fstall = fs; ferr = fe;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_ack_a"}, 32'(wb_a.o_wb_ack), 32'd0);
        check_output({tag, "_err_a"}, 32'(wb_a.o_wb_err), 32'd0);
        check_output({tag, "_dat_a"}, wb_a.o_wb_data, 32'd0);
        check_output({tag, "_ack_b"}, 32'(wb_b.o_wb_ack), 32'd0);
        check_output({tag, "_err_b"}, 32'(wb_b.o_wb_err), 32'd0);
        check_output({tag, "_dat_b"}, wb_b.o_wb_data, 32'd0);
    endtask

    // Reference model: at each edge, decide acceptance from the bus rules and schedule the
    // response at acceptance edge + latency - 1; an abort cancels anything not yet shown.
    always @(posedge i_clk) begin : model
        exp_t e;
        bit   oor;
        edge_cnt++;
        if (i_rst_n) begin
            if (!cyc) begin
                while (q_a.size() > 0 && q_a[q_a.size()-1].due >= edge_cnt) void'(q_a.pop_back());
                while (q_b.size() > 0 && q_b[q_b.size()-1].due >= edge_cnt) void'(q_b.pop_back());
            end
            if (cyc && stb && !fstall) begin
                oor      = (addr >= 32'(DEPTH));
                e.is_err = ferr || (oor && OOR_ERR);
                e.data   = (ferr || oor || we) ? 32'd0 : mdl_mem[addr[6:0]];
                if (we && !ferr && !oor) mdl_mem[addr[6:0]] = wdata;
                e.due = edge_cnt + LAT_A - 1;
                q_a.push_back(e);
                e.due = edge_cnt + LAT_B - 1;
                q_b.push_back(e);
            end
        end
    end

    always @(negedge i_clk) begin : mon_a
        exp_t e;
        bit   hit;
        if (i_rst_n) begin
            hit = (q_a.size() > 0) && (q_a[0].due == edge_cnt);
            e.due = 0; e.is_err = 1'b0; e.data = 32'd0;
            if (hit) e = q_a.pop_front();
            check_output("a_ack", 32'(wb_a.o_wb_ack), 32'(hit && !e.is_err));
            check_output("a_err", 32'(wb_a.o_wb_err), 32'(hit && e.is_err));
            check_output("a_data", wb_a.o_wb_data, (hit && !e.is_err) ? e.data : 32'd0);
        end
    end

    always @(negedge i_clk) begin : mon_b
        exp_t e;
        bit   hit;
        if (i_rst_n) begin
            hit = (q_b.size() > 0) && (q_b[0].due == edge_cnt);
            e.due = 0; e.is_err = 1'b0; e.data = 32'd0;
            if (hit) e = q_b.pop_front();
            check_output("b_ack", 32'(wb_b.o_wb_ack), 32'(hit && !e.is_err));
            check_output("b_err", 32'(wb_b.o_wb_err), 32'(hit && e.is_err));
            check_output("b_data", wb_b.o_wb_data, (hit && !e.is_err) ? e.data : 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r;

        repeat (3) @(negedge i_clk);
        #1;
        check_quiet("reset");
        fstall = 1'b1;
        #1;
        check_output("rst_stall_a", 32'(wb_a.o_wb_stall), 32'd1);
        fstall = 1'b0;
        #1;
        check_output("rst_stall_b", 32'(wb_b.o_wb_stall), 32'd0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;

        $display("[TB] preload all words");
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);

        $display("[TB] read-after-write and back-to-back reads");
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'(i), 32'd0, 1'b0, 1'b0);

        $display("[TB] forced stall on addr 9");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 32'd9, 32'd0, 1'b1, 1'b0);
            #1 check_output("stall_hold", 32'(wb_b.o_wb_stall), 32'd1);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0);
        #1 check_output("stall_release", 32'(wb_a.o_wb_stall), 32'd0);

        $display("[TB] forced error and out-of-range");
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'd2, 32'h1234, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd200, 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h8000_0003, 32'hCAFE0001, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'd128, 32'hCAFE0002, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(6);

        $display("[TB] abort burst by dropping cyc");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'(10 + i), 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(8);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'(20 + i), 32'd0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        #1 check_quiet("midrst");
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        idle(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)      a = 32'd128 + 32'($urandom_range(0, 200));
            else if (r < 5) a = $urandom;
            else            a = 32'($urandom_range(0, DEPTH - 1));
            apply_stimulus(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 1)), a, $urandom,
                           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
        end
        idle(8);
        check_output("drain_a", 32'(q_a.size()), 32'd0);
        check_output("drain_b", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
